bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/serdes_pkg.sv | 12 +
 rtl/bit_serializer.sv | 110 +++++++++++
 tb/tb_bit_serializer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// Shared types and defaults for the serializer/deserializer blocks.
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } ser_state_t;

  localparam int SER_WIDTH_DEFAULT = 3;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter, MSB first, with a valid/ready load handshake.
// Define SER_PARITY_EN to append an even-parity bit to every frame.
module bit_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_stall,
  output logic             ser_en,
  output logic             ser_out,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             frame_end;
  logic             take;
`ifdef SER_PARITY_EN
  logic             par;
`endif

  assign last_bit = (state == SHIFT) && (cnt == LAST);

`ifdef SER_PARITY_EN
  assign frame_end = (state == PARITY);
  assign ser_out   = (state == PARITY) ? par : shreg[WIDTH-1];
`else
  assign frame_end = last_bit;
  assign ser_out   = shreg[WIDTH-1];
`endif

  // Outputs decode registered state only; the stall input gates the stream.
  assign busy       = (state != IDLE);
  assign ser_en     = busy && !ser_stall;
  assign frame_done = frame_end && !ser_stall;
  assign load_ready = (state == IDLE) || frame_done;
  assign take       = load_valid && load_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
`ifdef SER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            shreg <= load_data;
            cnt   <= '0;
`ifdef SER_PARITY_EN
            par   <= ^load_data;
`endif
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!ser_stall) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            if (last_bit) begin
              cnt <= '0;
`ifdef SER_PARITY_EN
              state <= PARITY;
`else
              // A word waiting at the final bit starts the next frame with no gap.
              if (take) begin
                shreg <= load_data;
                state <= SHIFT;
              end else begin
                state <= IDLE;
              end
`endif
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
`ifdef SER_PARITY_EN
        PARITY: begin
          if (!ser_stall) begin
            if (take) begin
              shreg <= load_data;
              cnt   <= '0;
              par   <= ^load_data;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer (WIDTH=3): directed vector table,
// hand-written reset sequence and randomized traffic against a queue model.
module tb_bit_serializer;

  localparam int W = 3;
`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         nRST;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         ser_stall;
  logic         ser_en;
  logic         ser_out;
  logic         frame_done;
  logic         busy;

  int checks = 0;
  int passes = 0;

  // Bits of the current frame still to be emitted; empty means idle.
  bit pend[$];

  typedef struct {
    logic         lv;
    logic [W-1:0] d;
    logic         st;
    logic         en;
    logic         out;
    logic         done;
    logic         rdy;
    logic         bsy;
  } vec_t;

  vec_t vecs[$];

  always #5 CLK = ~CLK;

  bit_serializer #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .ser_stall (ser_stall),
    .ser_en    (ser_en),
    .ser_out   (ser_out),
    .frame_done(frame_done),
    .busy      (busy)
  );

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic lv, input logic [W-1:0] d, input logic st);
    load_valid = lv;
    load_data  = d;
    ser_stall  = st;
    #1;
  endtask

  function automatic void modelLoad(input logic [W-1:0] d);
    pend.delete();
    for (int i = W - 1; i >= 0; i--) pend.push_back(d[i]);
    if (PAR) pend.push_back(^d);
  endfunction

  // Predict this cycle's outputs from the pending bits, compare, then advance.
  task automatic modelCycle(input logic lv, input logic [W-1:0] d, input logic st);
    logic e_en, e_out, e_done, e_rdy, e_busy;
    bit   b;
    e_en = 1'b0; e_out = 1'b0; e_done = 1'b0; e_rdy = 1'b1; e_busy = 1'b0;
    if (pend.size() != 0) begin
      e_busy = 1'b1;
      e_out  = pend[0];
      e_rdy  = 1'b0;
      if (!st) begin
        e_en = 1'b1;
        if (pend.size() == 1) begin
          e_done = 1'b1;
          e_rdy  = 1'b1;
        end
      end
    end
    checkOutput("model ser_en", ser_en, e_en);
    checkOutput("model ser_out", ser_out, e_out);
    checkOutput("model frame_done", frame_done, e_done);
    checkOutput("model load_ready", load_ready, e_rdy);
    checkOutput("model busy", busy, e_busy);
    if (pend.size() == 0) begin
      if (lv) modelLoad(d);
    end else if (!st) begin
      b = pend.pop_front();
      if (pend.size() == 0 && lv) modelLoad(d);
    end
  endtask

  task automatic step(input logic lv, input logic [W-1:0] d, input logic st);
    applyStimulus(lv, d, st);
    modelCycle(lv, d, st);
    @(negedge CLK);
  endtask

  function automatic void addVec(input logic lv, input logic [W-1:0] d, input logic st,
                                 input logic en, input logic out, input logic done,
                                 input logic rdy, input logic bsy);
    vec_t v;
    v = '{lv, d, st, en, out, done, rdy, bsy};
    vecs.push_back(v);
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " ser_en"}, ser_en, 1'b0);
    checkOutput({tag, " ser_out"}, ser_out, 1'b0);
    checkOutput({tag, " frame_done"}, frame_done, 1'b0);
    checkOutput({tag, " busy"}, busy, 1'b0);
    checkOutput({tag, " load_ready"}, load_ready, 1'b1);
  endtask

  initial begin
`ifdef SER_PARITY_EN
    // 101 -> 1,0,1,0
    addVec(1, 3'b101, 0, 0, 0, 0, 1, 0);
    addVec(0, 3'b000, 0, 1, 1, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 0, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 1, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 0, 1, 1, 1);
    addVec(0, 3'b000, 0, 0, 0, 0, 1, 0);
    // 111 -> 1,1,1,1
    addVec(1, 3'b111, 0, 0, 0, 0, 1, 0);
    addVec(0, 3'b000, 0, 1, 1, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 1, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 1, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 1, 1, 1, 1);
    addVec(0, 3'b000, 0, 0, 0, 0, 1, 0);
    // back-to-back 110, 011 -> 1,1,0,0,0,1,1,0
    addVec(1, 3'b110, 0, 0, 0, 0, 1, 0);
    addVec(1, 3'b011, 0, 1, 1, 0, 0, 1);
    addVec(1, 3'b011, 0, 1, 1, 0, 0, 1);
    addVec(1, 3'b011, 0, 1, 0, 0, 0, 1);
    addVec(1, 3'b011, 0, 1, 0, 1, 1, 1);
    addVec(0, 3'b000, 0, 1, 0, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 1, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 1, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 0, 1, 1, 1);
    addVec(0, 3'b000, 0, 0, 0, 0, 1, 0);
    // 100 with a 2-cycle stall after the first bit -> 1,0,0,1
    addVec(1, 3'b100, 0, 0, 0, 0, 1, 0);
    addVec(0, 3'b000, 0, 1, 1, 0, 0, 1);
    addVec(1, 3'b111, 1, 0, 0, 0, 0, 1);
    addVec(1, 3'b111, 1, 0, 0, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 0, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 0, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 1, 1, 1, 1);
    addVec(0, 3'b000, 0, 0, 0, 0, 1, 0);
`else
    // 101 -> 1,0,1
    addVec(1, 3'b101, 0, 0, 0, 0, 1, 0);
    addVec(0, 3'b000, 0, 1, 1, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 0, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 1, 1, 1, 1);
    addVec(0, 3'b000, 0, 0, 0, 0, 1, 0);
    // 111 -> 1,1,1
    addVec(1, 3'b111, 0, 0, 0, 0, 1, 0);
    addVec(0, 3'b000, 0, 1, 1, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 1, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 1, 1, 1, 1);
    addVec(0, 3'b000, 0, 0, 0, 0, 1, 0);
    // back-to-back 110, 011 -> 1,1,0,0,1,1
    addVec(1, 3'b110, 0, 0, 0, 0, 1, 0);
    addVec(1, 3'b011, 0, 1, 1, 0, 0, 1);
    addVec(1, 3'b011, 0, 1, 1, 0, 0, 1);
    addVec(1, 3'b011, 0, 1, 0, 1, 1, 1);
    addVec(0, 3'b000, 0, 1, 0, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 1, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 1, 1, 1, 1);
    addVec(0, 3'b000, 0, 0, 0, 0, 1, 0);
    // 100 with a 2-cycle stall after the first bit -> 1,0,0
    addVec(1, 3'b100, 0, 0, 0, 0, 1, 0);
    addVec(0, 3'b000, 0, 1, 1, 0, 0, 1);
    addVec(1, 3'b111, 1, 0, 0, 0, 0, 1);
    addVec(1, 3'b111, 1, 0, 0, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 0, 0, 0, 1);
    addVec(0, 3'b000, 0, 1, 0, 1, 1, 1);
    addVec(0, 3'b000, 0, 0, 0, 0, 1, 0);
`endif

    nRST       = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    ser_stall  = 1'b0;
    #2;
    checkResetValues("reset");
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].lv, vecs[i].d, vecs[i].st);
      checkOutput($sformatf("vec%0d ser_en", i), ser_en, vecs[i].en);
      checkOutput($sformatf("vec%0d ser_out", i), ser_out, vecs[i].out);
      checkOutput($sformatf("vec%0d frame_done", i), frame_done, vecs[i].done);
      checkOutput($sformatf("vec%0d load_ready", i), load_ready, vecs[i].rdy);
      checkOutput($sformatf("vec%0d busy", i), busy, vecs[i].bsy);
      modelCycle(vecs[i].lv, vecs[i].d, vecs[i].st);
      @(negedge CLK);
    end

    // Reset after the 2nd bit of 111 drops the frame without frame_done.
    step(1, 3'b111, 0);
    step(0, 3'b000, 0);
    step(0, 3'b000, 0);
    nRST = 1'b0;
    applyStimulus(0, 3'b000, 0);
    checkResetValues("midreset");
    pend.delete();
    @(negedge CLK);
    applyStimulus(1, 3'b101, 1);
    checkResetValues("heldreset");
    @(negedge CLK);
    nRST = 1'b1;
    step(1, 3'b010, 0);
    applyStimulus(0, 3'b000, 0);
    checkOutput("post-reset bit0", ser_out, 1'b0);
    checkOutput("post-reset en0", ser_en, 1'b1);
    modelCycle(0, 3'b000, 0);
    @(negedge CLK);
    applyStimulus(0, 3'b000, 0);
    checkOutput("post-reset bit1", ser_out, 1'b1);
    modelCycle(0, 3'b000, 0);
    @(negedge CLK);
    applyStimulus(0, 3'b000, 0);
    checkOutput("post-reset bit2", ser_out, 1'b0);
    modelCycle(0, 3'b000, 0);
    @(negedge CLK);
    for (int i = 0; i < (PAR ? 2 : 1); i++) step(0, 3'b000, 0);

    // Idle with stall toggling: nothing moves.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, W'($urandom), logic'(i % 2));
      checkOutput("idle ser_en", ser_en, 1'b0);
      checkOutput("idle busy", busy, 1'b0);
      checkOutput("idle load_ready", load_ready, 1'b1);
      modelCycle(0, load_data, ser_stall);
      @(negedge CLK);
    end

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(0, 1)), W'($urandom), logic'($urandom_range(0, 9) < 3));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
